// File: rtl/seg_counter_scan.sv
// seg_counter_scan: NUM_DIGITS hex/BCD up/down counter driving a
// time-multiplexed common-anode seven-segment display bank.
module seg_counter_scan #(
    parameter int NUM_DIGITS = 8,
    parameter int TICK_DIV   = 50_000_000,
    parameter int SCAN_DIV   = 100_000,
    parameter int BCD        = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    isUP,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    input  logic [NUM_DIGITS-1:0]   dp_sel,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    wrap,
    output logic [6:0]              out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    dp
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [3:0]    DIG_MAX   = (BCD != 0) ? 4'd9 : 4'd15;

    logic [PW-1:0]           presc;
    logic [SW-1:0]           scan_cnt;
    logic [IW-1:0]           idx;
    logic                    tick;
    logic                    carry;
    logic [4*NUM_DIGITS-1:0] next_value;
    logic [NUM_DIGITS-1:0]   an_next;
    logic [3:0]              cur_digit;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign tick = en && (presc == PRE_LAST);

    // Ripple carry/borrow; carry out of the top digit marks a full wrap.
    always_comb begin
        logic [3:0] d;
        d          = 4'd0;
        next_value = value;
        carry      = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = value[4*i +: 4];
            if (carry) begin
                if (isUP) begin
                    if (d >= DIG_MAX) begin
                        d = 4'd0;
                    end else begin
                        d     = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = DIG_MAX;
                    end else begin
                        d     = d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            next_value[4*i +: 4] = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            value <= '0;
            wrap  <= 1'b0;
        end else if (load) begin
            presc <= '0;
            value <= load_val;
            wrap  <= 1'b0;
        end else begin
            wrap <= tick && carry;
            if (tick) begin
                presc <= '0;
                value <= next_value;
            end else if (en) begin
                presc <= presc + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    always_comb begin
        an_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) an_next[i] = 1'b0;
        end
    end

    assign cur_digit = value[{idx, 2'b00} +: 4];

    // Anode, segments and dp share one register stage so they never skew.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_out <= '1;
            out    <= 7'b1111111;
            dp     <= 1'b1;
        end else begin
            an_out <= an_next;
            out    <= seg7(cur_digit);
            dp     <= ~dp_sel[idx];
        end
    end

endmodule
